// File: rtl/ram_pdp_banked_wrap.sv
// Pseudo-dual-port RAM built from single-port banks with a posted-write FIFO.
// Reads always win their bank. A write that collides with a read on the same
// bank, or that arrives while earlier writes are still pending, is posted and
// drained later from the FIFO head. Reads forward from the youngest matching
// pending entry, so a write is visible to any read issued after it is accepted.
module ram_pdp_banked_wrap #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 6,
  parameter int BANK_BIT   = 1,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  wbuf_empty
);

  localparam int NUM_BANKS = 1 << BANK_BIT;
  localparam int ROW_W     = ADDR_WIDTH - BANK_BIT;
  localparam int ROWS      = 1 << ROW_W;
  localparam int BW        = (BANK_BIT == 0) ? 1 : BANK_BIT;
  localparam int CW        = $clog2(WBUF_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(NUM_BANKS - 1);

  function automatic logic [BW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
    return BW'(a & BANK_MASK);
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
    return ROW_W'(a >> BANK_BIT);
  endfunction

  // Posted-write FIFO, stored as a shift register: index 0 is the head (oldest).
  logic [ADDR_WIDTH-1:0] buf_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_data [WBUF_DEPTH];
  logic [CW-1:0]         count;

  logic [ADDR_WIDTH-1:0] nxt_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] nxt_data [WBUF_DEPTH];
  logic [CW-1:0]         nxt_count;
  logic [CW-1:0]         enq_idx;

  logic [BW-1:0]         rd_bank;
  logic [ROW_W-1:0]      rd_row;
  logic                  wr_acc;
  logic                  direct;
  logic                  enq;
  logic                  drain;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  logic                  mem_we;
  logic [BW-1:0]         mem_bank;
  logic [ROW_W-1:0]      mem_row;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

  assign wr_ready   = (count < CW'(WBUF_DEPTH));
  assign wbuf_empty = (count == '0);
  assign rd_bank    = bank_of(rd_addr);
  assign rd_row     = row_of(rd_addr);

  // Write routing, drain decision, forwarding lookup and FIFO next state.
  always_comb begin
    wr_acc    = wr_en && wr_ready;
    direct    = wr_acc && (count == '0) && !(rd_en && (bank_of(wr_addr) == rd_bank));
    enq       = wr_acc && !direct;
    drain     = (count != '0) && !(rd_en && (bank_of(buf_addr[0]) == rd_bank));

    mem_we    = direct || drain;
    mem_bank  = direct ? bank_of(wr_addr) : bank_of(buf_addr[0]);
    mem_row   = direct ? row_of(wr_addr)  : row_of(buf_addr[0]);
    mem_wdata = direct ? wr_data          : buf_data[0];

    // Later entries override earlier ones, so the youngest match wins.
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((CW'(i) < count) && (buf_addr[i] == rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data[i];
      end
    end

    nxt_addr = buf_addr;
    nxt_data = buf_data;
    if (drain) begin
      for (int i = 0; i < WBUF_DEPTH - 1; i++) begin
        nxt_addr[i] = buf_addr[i+1];
        nxt_data[i] = buf_data[i+1];
      end
    end
    enq_idx = count - CW'(drain);
    if (enq) begin
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        if (CW'(i) == enq_idx) begin
          nxt_addr[i] = wr_addr;
          nxt_data[i] = wr_data;
        end
      end
    end
    nxt_count = count + CW'(enq) - CW'(drain);
  end

  // FIFO state; reset discards anything still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        buf_addr[i] <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      count    <= nxt_count;
      buf_addr <= nxt_addr;
      buf_data <= nxt_data;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] arr [ROWS];

    // Single-port bank write; the routing above never targets a bank being read.
    always_ff @(posedge clk) begin
      if (mem_we && (mem_bank == BW'(b))) begin
        arr[mem_row] <= mem_wdata;
      end
    end

    assign bank_rdata[b] = arr[rd_row];
  end

  // Registered read: pending data beats array contents; held while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= fwd_hit ? fwd_data : bank_rdata[rd_bank];
      end
    end
  end

endmodule

// File: tb/tb_ram_pdp_banked_wrap.sv
// Directed bench: u0 is the default two-bank build, u1 a single-bank build
// used for write back-pressure.
module tb_ram_pdp_banked_wrap;

  localparam int DW = 28;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;

  logic          rd_en0, wr_en0, rd_valid0, wr_ready0, wbuf_empty0;
  logic [AW-1:0] rd_addr0, wr_addr0;
  logic [DW-1:0] wr_data0, rd_data0;

  logic          rd_en1, wr_en1, rd_valid1, wr_ready1, wbuf_empty1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [DW-1:0] wr_data1, rd_data1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_pdp_banked_wrap #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_BIT(1), .WBUF_DEPTH(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .wr_ready(wr_ready0), .wbuf_empty(wbuf_empty0)
  );

  ram_pdp_banked_wrap #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_BIT(0), .WBUF_DEPTH(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .wr_ready(wr_ready1), .wbuf_empty(wbuf_empty1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic re, input logic [AW-1:0] ra,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    rd_en0 = re; rd_addr0 = ra; wr_en0 = we; wr_addr0 = wa; wr_data0 = wd;
  endtask

  task automatic drive1(input logic re, input logic [AW-1:0] ra,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    rd_en1 = re; rd_addr1 = ra; wr_en1 = we; wr_addr1 = wa; wr_data1 = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    tests++; if (rd_data0 !== 28'h0) begin fails++; $display("FAIL reset_rd_data got %h want 0", rd_data0); end
    tests++; if (rd_valid0 !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b want 0", rd_valid0); end
    tests++; if (wbuf_empty0 !== 1'b1) begin fails++; $display("FAIL reset_wbuf_empty got %b want 1", wbuf_empty0); end
    tests++; if (wr_ready0 !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %b want 1", wr_ready0); end
    tests++; if (wr_ready1 !== 1'b1) begin fails++; $display("FAIL reset_wr_ready_u1 got %b want 1", wr_ready1); end
  endtask

  task automatic test_basic();
    drive0(0, 0, 1, 6'd5, 28'h0ABCDEF); step();
    drive0(0, 0, 0, 0, 0); step();
    drive0(1, 6'd5, 0, 0, 0); step();
    tests++; if (rd_valid0 !== 1'b1) begin fails++; $display("FAIL basic_rd_valid got %b want 1", rd_valid0); end
    tests++; if (rd_data0 !== 28'h0ABCDEF) begin fails++; $display("FAIL basic_rd_data got %h want 0abcdef", rd_data0); end
    drive0(0, 0, 0, 0, 0); step();
    tests++; if (rd_valid0 !== 1'b0) begin fails++; $display("FAIL basic_valid_fall got %b want 0", rd_valid0); end
    step();
    tests++; if (rd_data0 !== 28'h0ABCDEF) begin fails++; $display("FAIL basic_hold got %h want 0abcdef", rd_data0); end
  endtask

  task automatic test_diff_bank();
    drive0(1, 6'd2, 1, 6'd3, 28'h1234567); step();
    tests++; if (wbuf_empty0 !== 1'b1) begin fails++; $display("FAIL diff_direct_empty got %b want 1", wbuf_empty0); end
    drive0(1, 6'd3, 0, 0, 0); step();
    tests++; if (rd_data0 !== 28'h1234567) begin fails++; $display("FAIL diff_readback got %h want 1234567", rd_data0); end
    drive0(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_same_bank();
    drive0(1, 6'd4, 1, 6'd6, 28'h00000AA); step();
    tests++; if (wbuf_empty0 !== 1'b0) begin fails++; $display("FAIL same_enq_empty got %b want 0", wbuf_empty0); end
    drive0(1, 6'd6, 0, 0, 0); step();
    tests++; if (rd_data0 !== 28'h00000AA) begin fails++; $display("FAIL same_forward got %h want 00000aa", rd_data0); end
    tests++; if (wbuf_empty0 !== 1'b0) begin fails++; $display("FAIL same_blocked_empty got %b want 0", wbuf_empty0); end
    drive0(0, 0, 0, 0, 0); step();
    tests++; if (wbuf_empty0 !== 1'b1) begin fails++; $display("FAIL same_drained_empty got %b want 1", wbuf_empty0); end
    drive0(1, 6'd6, 0, 0, 0); step();
    tests++; if (rd_data0 !== 28'h00000AA) begin fails++; $display("FAIL same_array got %h want 00000aa", rd_data0); end
    drive0(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_youngest();
    drive0(1, 6'd1, 1, 6'd9, 28'h1); step();
    drive0(1, 6'd1, 1, 6'd9, 28'h2); step();
    tests++; if (wr_ready0 !== 1'b0) begin fails++; $display("FAIL young_full_ready got %b want 0", wr_ready0); end
    drive0(1, 6'd9, 0, 0, 0); step();
    tests++; if (rd_data0 !== 28'h2) begin fails++; $display("FAIL young_forward got %h want 2", rd_data0); end
    drive0(0, 0, 0, 0, 0); step(); step();
    tests++; if (wbuf_empty0 !== 1'b1) begin fails++; $display("FAIL young_drained got %b want 1", wbuf_empty0); end
    drive0(1, 6'd9, 0, 0, 0); step();
    tests++; if (rd_data0 !== 28'h2) begin fails++; $display("FAIL young_array got %h want 2", rd_data0); end
    drive0(1, 6'd9, 1, 6'd9, 28'h3); step();
    tests++; if (rd_data0 !== 28'h2) begin fails++; $display("FAIL rbw_old got %h want 2", rd_data0); end
    drive0(1, 6'd9, 0, 0, 0); step();
    tests++; if (rd_data0 !== 28'h3) begin fails++; $display("FAIL rbw_new got %h want 3", rd_data0); end
    drive0(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_back_to_back();
    drive1(1, 6'd0, 1, 6'd10, 28'h111); step();
    tests++; if (wr_ready1 !== 1'b1) begin fails++; $display("FAIL bp_ready_after1 got %b want 1", wr_ready1); end
    drive1(1, 6'd0, 1, 6'd10, 28'h222); step();
    tests++; if (wr_ready1 !== 1'b0) begin fails++; $display("FAIL bp_ready_after2 got %b want 0", wr_ready1); end
    drive1(1, 6'd0, 1, 6'd10, 28'h333); step();
    tests++; if (wr_ready1 !== 1'b0) begin fails++; $display("FAIL bp_ready_third got %b want 0", wr_ready1); end
    drive1(0, 0, 0, 0, 0); step();
    tests++; if (wr_ready1 !== 1'b1) begin fails++; $display("FAIL bp_first_drain got %b want 1", wr_ready1); end
    tests++; if (wbuf_empty1 !== 1'b0) begin fails++; $display("FAIL bp_one_left got %b want 0", wbuf_empty1); end
    step();
    tests++; if (wbuf_empty1 !== 1'b1) begin fails++; $display("FAIL bp_all_drained got %b want 1", wbuf_empty1); end
    drive1(1, 6'd10, 0, 0, 0); step();
    tests++; if (rd_data1 !== 28'h222) begin fails++; $display("FAIL bp_final_contents got %h want 0000222", rd_data1); end
    drive1(0, 0, 0, 0, 0); step();
  endtask

  task automatic test_reset_mid();
    drive0(0, 0, 1, 6'd20, 28'h555); step();
    drive0(0, 0, 1, 6'd21, 28'h444); step();
    drive0(1, 6'd1, 1, 6'd21, 28'h666); step();
    drive0(1, 6'd1, 1, 6'd23, 28'h777); step();
    tests++; if (wr_ready0 !== 1'b0) begin fails++; $display("FAIL mid_full got %b want 0", wr_ready0); end
    rst_n = 1'b0;
    #1;
    tests++; if (wbuf_empty0 !== 1'b1) begin fails++; $display("FAIL mid_rst_empty got %b want 1", wbuf_empty0); end
    tests++; if (wr_ready0 !== 1'b1) begin fails++; $display("FAIL mid_rst_ready got %b want 1", wr_ready0); end
    tests++; if (rd_valid0 !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %b want 0", rd_valid0); end
    drive0(0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    step();
    drive0(1, 6'd21, 0, 0, 0); step();
    tests++; if (rd_data0 !== 28'h444) begin fails++; $display("FAIL mid_discarded got %h want 0000444", rd_data0); end
    drive0(1, 6'd20, 0, 0, 0); step();
    tests++; if (rd_data0 !== 28'h555) begin fails++; $display("FAIL mid_persist got %h want 0000555", rd_data0); end
    drive0(0, 0, 0, 0, 0); step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_diff_bank();
    test_same_bank();
    test_youngest();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
